ex_flag_stage: RTL and testbench

EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

---
 rtl/alu_pkg.sv | 32 +++
 rtl/sat_flag_calc.sv | 62 ++++++
 rtl/ex_flag_stage.sv | 66 ++++++
 tb/tb_ex_flag_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the execute stage.
//   - op_e        : operation encodings (undefined codes 6/7 behave as PASS)
//   - SAT_MAX/MIN : signed 16-bit saturation limits
//   - FLAG_Z/V/N  : bit positions of the zero, overflow and negative flags
//   - add_overflow: signed overflow of an adder given its operands and sum
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_XOR    = 3'd2,
    OP_RED    = 3'd3,
    OP_PADDSB = 3'd4,
    OP_PASS   = 3'd5
  } op_e;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Overflow when both operands share a sign and the sum's sign differs.
  // Operand B is already inverted for SUB, so one rule covers ADD and SUB.
  function automatic logic add_overflow(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] sum);
    return (a[15] == b[15]) && (sum[15] != a[15]);
  endfunction

endpackage

// File: rtl/sat_flag_calc.sv
// sat_flag_calc: combinational saturation and next-flag computation.
// Ports:
//   op        in  3   operation code (alu_pkg::op_e encodings)
//   op_a      in  16  adder operand A
//   op_b      in  16  adder operand B (already inverted for SUB)
//   sum_raw   in  16  unsaturated adder sum
//   alt_res   in  16  result for all non-ADD/SUB ops
//   flags_cur in  3   current {Z,V,N} flag register
//   res       out 16  final result to be captured
//   flags_nxt out 3   flag value to load if this result is accepted
module sat_flag_calc
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] sum_raw,
  input  logic [15:0] alt_res,
  input  logic [2:0]  flags_cur,
  output logic [15:0] res,
  output logic [2:0]  flags_nxt
);

  logic        ovf_s;
  logic [15:0] sat_s;

  // Saturate the adder sum toward the sign of operand A on overflow.
  always_comb begin
    ovf_s = add_overflow(op_a, op_b, sum_raw);
    if (ovf_s) begin
      if (op_a[15]) begin
        sat_s = SAT_MIN;
      end else begin
        sat_s = SAT_MAX;
      end
    end else begin
      sat_s = sum_raw;
    end
  end

  // Select the result and the flags each op is allowed to touch; the rest hold.
  always_comb begin
    res       = alt_res;
    flags_nxt = flags_cur;
    case (op)
      OP_ADD, OP_SUB: begin
        res               = sat_s;
        flags_nxt[FLAG_Z] = (sat_s == 16'h0000);
        flags_nxt[FLAG_V] = ovf_s;
        flags_nxt[FLAG_N] = sat_s[15];
      end
      OP_XOR: begin
        flags_nxt[FLAG_Z] = (alt_res == 16'h0000);
      end
      default: begin
        res       = alt_res;
        flags_nxt = flags_cur;
      end
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: one-entry output register for the ALU result plus the
// {Z,V,N} flag register, with a valid/ready handshake on both sides.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   in_valid/ready upstream handshake (in_ready is combinational)
//   op, op_a, op_b, sum_raw, alt_res  upstream ALU data
//   flush          drop this cycle's capture and invalidate the held result
//   out_valid/ready downstream handshake
//   result         registered final result
//   flags          registered {Z,V,N}
module ex_flag_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] sum_raw,
  input  logic [15:0] alt_res,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  logic        accept_s;
  logic [15:0] calc_res_s;
  logic [2:0]  calc_flags_s;

  sat_flag_calc u_calc (
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .sum_raw   (sum_raw),
    .alt_res   (alt_res),
    .flags_cur (flags),
    .res       (calc_res_s),
    .flags_nxt (calc_flags_s)
  );

  // Ready whenever the register is empty or is being drained this cycle.
  assign in_ready = !out_valid | out_ready;
  assign accept_s = in_valid & in_ready & !flush;

  // Output register and flag register; flush wins over capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 16'h0000;
      flags     <= 3'b000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      result    <= calc_res_s;
      flags     <= calc_flags_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic [15:0] sum_raw = 16'h0000;
  logic [15:0] alt_res = 16'h0000;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic        m_valid = 1'b0;
  logic [15:0] m_result = 16'h0000;
  logic        m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;

  ex_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b), .sum_raw(sum_raw), .alt_res(alt_res),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, m_valid});
    check({tag, ".result"}, result, m_result);
    check({tag, ".flags"}, {13'd0, flags}, {13'd0, m_z, m_v, m_n});
  endtask

  // Drive one cycle of stimulus, predict the edge from signed arithmetic,
  // then compare after the edge.
  task automatic apply(input string tag, input logic iv, input logic [2:0] o,
                       input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] alt, input logic fl, input logic ordy);
    int          true_sum;
    logic [31:0] tmp;
    logic [15:0] sat;
    logic        ovf, acc, rdy;
    in_valid  = iv;
    op        = o;
    op_a      = a;
    op_b      = b;
    sum_raw   = a + b + {15'd0, cin};
    alt_res   = alt;
    flush     = fl;
    out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, rdy});
    true_sum = int'($signed(a)) + int'($signed(b)) + int'(cin);
    ovf = 1'b0;
    if (true_sum > 32767) begin
      sat = 16'h7FFF; ovf = 1'b1;
    end else if (true_sum < -32768) begin
      sat = 16'h8000; ovf = 1'b1;
    end else begin
      tmp = true_sum;
      sat = tmp[15:0];
    end
    acc = iv && rdy && !fl;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      if (o == 3'd0 || o == 3'd1) begin
        m_result = sat;
        m_z = (sat == 16'h0000);
        m_v = ovf;
        m_n = (true_sum < 0) || ovf && a[15];
      end else begin
        m_result = alt;
        if (o == 3'd2) m_z = (alt == 16'h0000);
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_result = 16'h0000; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
    check(tag, {13'd0, flags}, 16'h0000);
    check({tag, ".result"}, result, 16'h0000);
    check({tag, ".out_valid"}, {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    check("reset.out_valid", {15'd0, out_valid}, 16'h0000);
    check("reset.result", result, 16'h0000);
    check("reset.flags", {13'd0, flags}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts
    apply("first_accept", 1'b1, 3'd0, 16'h0001, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("first_accept.const", result, 16'h0003);
    // Positive overflow
    apply("pos_ovf", 1'b1, 3'd0, 16'h7000, 16'h2000, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("pos_ovf.res_const", result, 16'h7FFF);
    check("pos_ovf.flags_const", {13'd0, flags}, 16'h0002);
    // Negative overflow via SUB (inverted B, carry-in 1)
    apply("neg_ovf", 1'b1, 3'd1, 16'h8000, 16'hFFFE, 1'b1, 16'h0000, 1'b0, 1'b1);
    check("neg_ovf.res_const", result, 16'h8000);
    check("neg_ovf.flags_const", {13'd0, flags}, 16'h0003);
    // XOR zero updates Z only
    apply("xor_hold", 1'b1, 3'd2, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("xor_hold.flags_const", {13'd0, flags}, 16'h0007);
    // RED / PADDSB / PASS / undefined: flags hold, result is alt_res
    apply("red", 1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0, 16'hA5A5, 1'b0, 1'b1);
    apply("undef", 1'b1, 3'd7, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("undef.flags_const", {13'd0, flags}, 16'h0007);
    // Clear Z, then flush collision with a zero sum
    apply("clear_z", 1'b1, 3'd0, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    apply("flush", 1'b1, 3'd0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("flush.z_const", {15'd0, flags[2]}, 16'h0000);
    check("flush.valid_const", {15'd0, out_valid}, 16'h0000);
    // Stall: capture then hold for 3 cycles, then drain-and-accept
    apply("stall_fill", 1'b1, 3'd0, 16'h0005, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply("stall_hold", 1'b1, 3'd0, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("stall.res_const", result, 16'h0008);
    apply("stall_release", 1'b1, 3'd0, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("stall_release.res_const", result, 16'h0200);
    // Drain with no accept
    apply("drain", 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Mid-stall reset
    apply("pre_rst", 1'b1, 3'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);
    apply("pre_rst_hold", 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    do_reset("mid_stall_rst");
    apply("post_rst_accept", 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra, rb, ralt;
      ro   = 3'($urandom_range(0, 7));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      ralt = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 5) == 0) rb = -ra;
      apply("rand", ($urandom_range(0, 3) != 0), ro, ra, rb,
            (ro == 3'd1) ? 1'b1 : 1'b0, ralt,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
